// File: rtl/chunked_adder.sv
// Multi-cycle adder: adds CHUNK bits per clock through a CALC phase, then holds the result in DONE.
// Build with ADDER_SUB_EN defined to add the sub port (a - b - cin as a + ~b + !cin).
module chunked_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LastIdx = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, carry_q;
    logic [IDXW-1:0]  idx_q;

    logic             sub_eff;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef ADDER_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    // Subtraction folds into addition: invert b and the borrow-in.
    assign b_eff   = sub_eff ? ~b : b;
    assign cin_eff = cin ^ sub_eff;

    // Operands shift right each CALC cycle, so the current chunk is always the low CHUNK bits.
    logic [CHUNK-1:0] ca, cb;
    logic [CHUNK:0]   csum;
    logic             carry_into_msb;
    logic [WIDTH-1:0] acc_next;

    assign ca   = a_q[CHUNK-1:0];
    assign cb   = b_q[CHUNK-1:0];
    assign csum = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry_q};
    assign carry_into_msb = csum[CHUNK-1] ^ ca[CHUNK-1] ^ cb[CHUNK-1];
    // New chunk enters at the top; after NCHUNK cycles chunk 0 has reached bit 0.
    assign acc_next = (acc_q >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_eff;
                        carry_q <= cin_eff;
                        idx_q   <= '0;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    carry_q <= csum[CHUNK];
                    acc_q   <= acc_next;
                    idx_q   <= idx_q + IDXW'(1);
                    if (idx_q == LastIdx) begin
                        sum_q   <= acc_next;
                        cout_q  <= csum[CHUNK];
                        ovf_q   <= carry_into_msb ^ csum[CHUNK];
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Randomised bench for chunked_adder (16/4 instance plus a 1-bit instance) against an
// integer-arithmetic reference model.
module tb_chunked_adder;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, cout, ovf;
    logic [W-1:0] sum;
`ifdef ADDER_SUB_EN
    logic         sub_v = 1'b0;
    logic         sub1 = 1'b0;
`endif

    logic a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, iv1 = 1'b0, or1 = 1'b1;
    logic ir1, ov1, s1, co1, of1;

    chunked_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef ADDER_SUB_EN
        .sub(sub_v),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    chunked_adder #(.WIDTH(1), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(cin1),
`ifdef ADDER_SUB_EN
        .sub(sub1),
`endif
        .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(of1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned sum with carry, and signed overflow from the true integer result.
    function automatic void model(input int w, input longint ua, input longint ub, input bit c,
                                  input bit s, output longint es, output bit ec, output bit eo);
        longint mask, half, t, sa, sb, r, ci;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ci   = longint'(c);
        t    = s ? (ua + ((~ub) & mask) + (1 - ci)) : (ua + ub + ci);
        es   = t & mask;
        ec   = ((t >> w) & 1) != 0;
        sa   = (ua >= half) ? ua - (mask + 1) : ua;
        sb   = (ub >= half) ? ub - (mask + 1) : ub;
        r    = s ? (sa - sb - ci) : (sa + sb + ci);
        eo   = (r < -half) || (r >= half);
    endfunction

    logic [W-1:0] last_sum = '0;
    logic         last_cout = 1'b0, last_ovf = 1'b0;

    // Call just before a clock edge while the DUT is idle.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input bit tc,
                         input bit ts, input int stall);
        longint       es;
        bit           ec, eo;
        int           lat;
        logic [W-1:0] esum;
        model(W, longint'(ta), longint'(tb_), tc, ts, es, ec, eo);
        esum = es[W-1:0];
        check_eq("in_ready idle", in_ready, 1);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
`ifdef ADDER_SUB_EN
        sub_v = ts;
`endif
        out_ready = (stall == 0);
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid && lat < 4 * N + 8) begin
            check_eq("calc sum hidden", sum, last_sum);
            check_eq("calc in_ready", in_ready, 0);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'($urandom);
`ifdef ADDER_SUB_EN
            sub_v = 1'($urandom);
`endif
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check_eq("latency", lat, N);
        check_eq("sum", sum, esum);
        check_eq("cout", cout, ec);
        check_eq("ovf", ovf, eo);
        check_eq("done in_ready", in_ready, 0);
        for (int k = 0; k < stall; k++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
            check_eq("stall out_valid", out_valid, 1);
            check_eq("stall sum", sum, esum);
            check_eq("stall cout", cout, ec);
            check_eq("stall ovf", ovf, eo);
            check_eq("stall in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("post out_valid", out_valid, 0);
        check_eq("post in_ready", in_ready, 1);
        in_valid = 1'b0;
        last_sum = esum; last_cout = ec; last_ovf = eo;
    endtask

    initial begin
        #1;
        check_eq("rst in_ready", in_ready, 1);
        check_eq("rst out_valid", out_valid, 0);
        check_eq("rst sum", sum, 0);
        check_eq("rst cout", cout, 0);
        check_eq("rst ovf", ovf, 0);
        check_eq("rst1 in_ready", ir1, 1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        // Accept at the very first edge with reset released.
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'h1234, 16'h1111, 1'b1, 1'b0, 3);
`ifdef ADDER_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1);
`endif

        // Reset during the second CALC cycle aborts the operation.
        a = 16'h4321; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort in_ready", in_ready, 1);
        check_eq("abort out_valid", out_valid, 0);
        check_eq("abort sum", sum, 0);
        check_eq("abort cout", cout, 0);
        check_eq("abort ovf", ovf, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int k = 0; k < N + 2; k++) begin
            @(posedge clk); #1;
            check_eq("abort no result", out_valid, 0);
        end
        last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
        do_op(16'h00FF, 16'h0F01, 1'b1, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            bit           rc, rs;
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op(ra, rb, rc, rs, int'($urandom_range(0, 2)));
        end

        // Full-adder truth table on the 1-bit instance.
        for (int i = 0; i < 8; i++) begin
            longint es;
            bit     ec, eo;
            logic [2:0] v;
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; cin1 = v[0];
            model(1, longint'(v[2]), longint'(v[1]), v[0], 1'b0, es, ec, eo);
            iv1 = 1'b1;
            @(posedge clk); #1;
            iv1 = 1'b0;
            check_eq("w1 in_ready busy", ir1, 0);
            @(posedge clk); #1;
            check_eq("w1 latency", ov1, 1);
            check_eq("w1 sum", s1, es[0]);
            check_eq("w1 cout", co1, ec);
            check_eq("w1 ovf", of1, eo);
            @(posedge clk); #1;
            check_eq("w1 idle", ir1, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; SHALL be at least 1.
REQ-002 Parameter CHUNK, default 4: bits added per cycle; SHALL divide WIDTH exactly. NCHUNK = WIDTH/CHUNK.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operands a, b and cin (plus sub when configured) are valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in (borrow-in in subtract mode).
REQ-011 sub  input  1  subtract select; present only with ADDER_SUB_EN.
REQ-012 out_valid  output  1  result is valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry-out.
REQ-016 ovf  output  1  signed overflow.

Function
REQ-017 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-018 In IDLE, in_ready SHALL be 1; in CALC and DONE it SHALL be 0.
REQ-019 Accept = in_valid & in_ready at a rising edge: a, b and cin (and sub) captured; chunk index set to 0; IDLE->CALC.
REQ-020 Each CALC cycle SHALL add chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) plus the running carry; chunk 0 uses the effective carry-in.
REQ-021 After chunk NCHUNK-1: CALC->DONE; out_valid=1 exactly NCHUNK cycles after the accepting edge.
REQ-022 sum, cout and ovf SHALL update only on entry to DONE and hold their values until the next result; partial results SHALL NOT be visible.
REQ-023 cout = carry out of bit WIDTH-1; ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-024 Arithmetic is modulo 2^WIDTH; result {cout,sum} = a + b + cin in add mode.
REQ-025 DONE with out_ready=1 at an edge: DONE->IDLE and out_valid=0; no same-cycle re-accept (next accept no earlier than the following edge).
REQ-026 DONE with out_ready=0: out_valid, sum, cout and ovf SHALL be held stable indefinitely.
REQ-027 Input changes during CALC or DONE SHALL be ignored.
REQ-028 WIDTH==CHUNK: CALC lasts one cycle; latency = 1.
REQ-029 Throughput: at most one operation per NCHUNK+2 cycles with out_ready held high.

Reset
REQ-030 rst_n low SHALL immediately force IDLE; out_valid=0, sum=0, cout=0, ovf=0, chunk index and carry=0; in_ready=1 while rst_n is low.
REQ-031 Reset asserted in CALC or DONE SHALL abort the operation; no result SHALL be produced for it.
REQ-032 The first accept after reset deassertion is permitted at the first rising edge with rst_n high.

Configuration
REQ-033 Macro ADDER_SUB_EN defined: sub port present; a sub=1 accept computes a - b - cin as a + ~b + (1 - cin); cout = NOT borrow; ovf is signed overflow of the subtraction.
REQ-034 ADDER_SUB_EN undefined: sub port absent; add mode only; logic otherwise identical.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-035 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; out_valid high 4 cycles after accept.
REQ-036 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x1234, b=0x1111, cin=1 -> sum=0x2346, cout=0.
REQ-037 out_ready=0 for 3 cycles in DONE, with in_valid=1 and new operands applied -> sum, cout and ovf stable; in_ready=0; new operands accepted only after the handshake plus one cycle.
REQ-038 rst_n pulsed low in the 2nd CALC cycle -> outputs 0, in_ready=1, no out_valid pulse; next operation is correct.
REQ-039 WIDTH=CHUNK=1, all 8 combinations of a, b, cin -> {cout,sum} matches the full-adder truth table (1,1,1 -> 1,1); latency 1.
REQ-040 With ADDER_SUB_EN: sub=1, a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.
